mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of Execute. Registers the Execute outputs (opcode, pc, ALU result, destination register, store data) and performs the data-memory access for loads and stores over a request/grant/rvalid bus.
- Presents a registered result to writeback through a valid/ready handshake.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage_if.sv | 44 ++++
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Signal bundle around the memory-access stage: Execute input, data-memory bus
// and writeback output. The slave modport is the stage's view, master the environment's.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              ex_valid;
    logic              ex_ready;
    logic [5:0]        ex_opcode;
    logic [31:0]       ex_pc;
    logic [31:0]       alu_out;
    logic [4:0]        ex_rf_dest;
    logic [31:0]       ex_mem_data;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;

    logic              mem_valid;
    logic              mem_ready;
    logic [5:0]        mem_opcode;
    logic [31:0]       mem_pc;
    logic [4:0]        mem_rf_dest;
    logic [31:0]       mem_result;
    logic              mem_misaligned;

    modport slave (
        input  ex_valid, ex_opcode, ex_pc, alu_out, ex_rf_dest, ex_mem_data,
        input  dmem_gnt, dmem_rvalid, dmem_rdata, mem_ready,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output mem_valid, mem_opcode, mem_pc, mem_rf_dest, mem_result, mem_misaligned
    );

    modport master (
        output ex_valid, ex_opcode, ex_pc, alu_out, ex_rf_dest, ex_mem_data,
        output dmem_gnt, dmem_rvalid, dmem_rdata, mem_ready,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  mem_valid, mem_opcode, mem_pc, mem_rf_dest, mem_result, mem_misaligned
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers Execute results, performs load/store
// over a req/gnt/rvalid bus and hands a registered result to writeback.
module mem_access_stage #(
    parameter int ADDR_W        = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_stage_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_t size_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return SZ_B;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return SZ_H;
        return SZ_W;
    endfunction

    // Lane offset after forcing alignment to the access size; identical to the
    // raw offset whenever the access is legal.
    function automatic logic [1:0] lane_off(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return a;
            SZ_H:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    state_t            state_reg;
    logic              dmem_req_reg;
    logic              dmem_we_reg;
    logic [ADDR_W-1:0] dmem_addr_reg;
    logic [3:0]        dmem_be_reg;
    logic [31:0]       dmem_wdata_reg;
    logic              mem_valid_reg;
    logic [5:0]        mem_opcode_reg;
    logic [31:0]       mem_pc_reg;
    logic [4:0]        mem_rf_dest_reg;
    logic [31:0]       mem_result_reg;
    logic              mem_misaligned_reg;
    logic [1:0]        off_reg;

    logic        ex_ready_int;
    logic        accept;
    logic        in_mem;
    logic        in_store;
    size_t       in_size;
    logic [1:0]  in_off;
    logic        in_misal;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    size_t       ld_size;
    logic [15:0] ld_lane;
    logic [31:0] ld_data;

    assign ex_ready_int = (state_reg == IDLE) || (state_reg == HOLD && bus.mem_ready);
    assign accept       = bus.ex_valid && ex_ready_int;

    // Decode straight from the Execute inputs so the accept edge already
    // knows which state to enter.
    always_comb begin
        in_store = is_store(bus.ex_opcode);
        in_mem   = in_store || is_load(bus.ex_opcode);
        in_size  = size_of(bus.ex_opcode);
        in_off   = lane_off(in_size, bus.alu_out[1:0]);
        in_misal = 1'b0;
        in_be    = 4'b1111;
        in_wdata = bus.ex_mem_data;
        case (in_size)
            SZ_B: begin
                in_be    = 4'b0001 << in_off;
                in_wdata = {4{bus.ex_mem_data[7:0]}};
            end
            SZ_H: begin
                in_misal = bus.alu_out[0];
                in_be    = in_off[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{bus.ex_mem_data[15:0]}};
            end
            default: in_misal = (bus.alu_out[1:0] != 2'b00);
        endcase
        in_misal = in_misal && in_mem && MISALIGN_TRAP;
    end

    always_comb begin
        ld_size = size_of(mem_opcode_reg);
        ld_lane = 16'(bus.dmem_rdata >> {off_reg, 3'b000});
        case (ld_size)
            SZ_B: ld_data = (mem_opcode_reg == OP_LBU) ? {24'd0, ld_lane[7:0]}
                                                       : {{24{ld_lane[7]}}, ld_lane[7:0]};
            SZ_H: ld_data = (mem_opcode_reg == OP_LHU) ? {16'd0, ld_lane}
                                                       : {{16{ld_lane[15]}}, ld_lane};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            dmem_req_reg       <= 1'b0;
            dmem_we_reg        <= 1'b0;
            dmem_addr_reg      <= '0;
            dmem_be_reg        <= 4'b0000;
            dmem_wdata_reg     <= 32'd0;
            mem_valid_reg      <= 1'b0;
            mem_opcode_reg     <= 6'd0;
            mem_pc_reg         <= 32'd0;
            mem_rf_dest_reg    <= 5'd0;
            mem_result_reg     <= 32'd0;
            mem_misaligned_reg <= 1'b0;
            off_reg            <= 2'b00;
        end else begin
            case (state_reg)
                IDLE, HOLD: begin
                    if (accept) begin
                        mem_opcode_reg     <= bus.ex_opcode;
                        mem_pc_reg         <= bus.ex_pc;
                        mem_result_reg     <= bus.alu_out;
                        mem_misaligned_reg <= in_misal;
                        off_reg            <= in_off;
                        dmem_we_reg        <= in_store;
                        dmem_addr_reg      <= {bus.alu_out[ADDR_W-1:2], 2'b00};
                        dmem_be_reg        <= in_be;
                        dmem_wdata_reg     <= in_wdata;
                        if (in_mem && !in_misal) begin
                            state_reg       <= REQ;
                            dmem_req_reg    <= 1'b1;
                            mem_valid_reg   <= 1'b0;
                            mem_rf_dest_reg <= in_store ? 5'd0 : bus.ex_rf_dest;
                        end else begin
                            state_reg       <= HOLD;
                            mem_valid_reg   <= 1'b1;
                            mem_rf_dest_reg <= in_misal ? 5'd0 : bus.ex_rf_dest;
                        end
                    end else if (state_reg == HOLD && bus.mem_ready) begin
                        state_reg     <= IDLE;
                        mem_valid_reg <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        dmem_req_reg <= 1'b0;
                        if (dmem_we_reg) begin
                            state_reg     <= HOLD;
                            mem_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.dmem_rvalid) begin
                        mem_result_reg <= ld_data;
                        mem_valid_reg  <= 1'b1;
                        state_reg      <= HOLD;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ex_ready       = ex_ready_int;
    assign bus.dmem_req       = dmem_req_reg;
    assign bus.dmem_we        = dmem_we_reg;
    assign bus.dmem_addr      = dmem_addr_reg;
    assign bus.dmem_be        = dmem_be_reg;
    assign bus.dmem_wdata     = dmem_wdata_reg;
    assign bus.mem_valid      = mem_valid_reg;
    assign bus.mem_opcode     = mem_opcode_reg;
    assign bus.mem_pc         = mem_pc_reg;
    assign bus.mem_rf_dest    = mem_rf_dest_reg;
    assign bus.mem_result     = mem_result_reg;
    assign bus.mem_misaligned = mem_misaligned_reg;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push expected
// writeback results; a monitor pops and compares on every mem_valid && mem_ready.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_stage_if #(.ADDR_W(32)) bus();

    mem_access_stage #(.ADDR_W(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc = 0;
    int   last_pop_cyc = 0;
    int   prev_pop_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] op, input logic [31:0] pc,
                                input logic [4:0] dest, input logic [31:0] res, input logic mis);
        exp_t e;
        e.op = op; e.pc = pc; e.dest = dest; e.res = res; e.mis = mis;
        return e;
    endfunction

    // Monitor: one line per retired transaction.
    always @(negedge clk) begin
        if (rst_n && bus.mem_valid && bus.mem_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_result: got op=0x%02h result=0x%08h, expected no transaction",
                         bus.mem_opcode, bus.mem_result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mem_opcode",     32'(bus.mem_opcode),     32'(e.op));
                check("mem_pc",         bus.mem_pc,              e.pc);
                check("mem_rf_dest",    32'(bus.mem_rf_dest),    32'(e.dest));
                check("mem_result",     bus.mem_result,          e.res);
                check("mem_misaligned", 32'(bus.mem_misaligned), 32'(e.mis));
                $display("txn op=0x%02h pc=0x%08h dest=%0d result=0x%08h mis=%0b",
                         bus.mem_opcode, bus.mem_pc, bus.mem_rf_dest, bus.mem_result, bus.mem_misaligned);
            end
            prev_pop_cyc = last_pop_cyc;
            last_pop_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present an instruction and return 1 time unit after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [4:0] dest, input logic [31:0] data);
        bus.ex_valid    = 1'b1;
        bus.ex_opcode   = op;
        bus.ex_pc       = pc;
        bus.alu_out     = alu;
        bus.ex_rf_dest  = dest;
        bus.ex_mem_data = data;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.ex_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_checks++;
        n_fails++;
        $display("FAIL issue_timeout: got no ex_ready in 50 cycles, expected acceptance of op 0x%02h", op);
    endtask

    // Grant after gnt_delay waiting cycles; for loads return rvalid one cycle later.
    task automatic mem_handshake(input int gnt_delay, input bit is_load,
                                 input logic [31:0] rdata, output int req_cycles);
        req_cycles = 0;
        for (int i = 0; i <= gnt_delay; i++) begin
            bus.dmem_gnt = (i == gnt_delay);
            @(negedge clk);
            if (bus.dmem_req) req_cycles++;
            @(posedge clk);
            #1;
        end
        bus.dmem_gnt = 1'b0;
        if (is_load) begin
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = rdata;
            @(posedge clk);
            #1;
            bus.dmem_rvalid = 1'b0;
        end
    endtask

    task automatic load_op(input logic [5:0] op, input logic [31:0] alu, input int gnt_delay,
                           input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] res);
        int rc;
        sb_q.push_back(mk(op, 32'h2000 + alu, 5'd6, res, 1'b0));
        issue(op, 32'h2000 + alu, alu, 5'd6, 32'h0);
        bus.ex_valid = 1'b0;
        check("load_req",  32'(bus.dmem_req), 32'd1);
        check("load_we",   32'(bus.dmem_we),  32'd0);
        check("load_be",   32'(bus.dmem_be),  32'(be));
        check("load_addr", bus.dmem_addr,     {alu[31:2], 2'b00});
        mem_handshake(gnt_delay, 1'b1, rdata, rc);
        check("load_req_cycles", 32'(rc), 32'(gnt_delay + 1));
        tick(2);
    endtask

    task automatic store_op(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] data,
                            input logic [3:0] be, input logic [31:0] wdata);
        int rc;
        sb_q.push_back(mk(op, 32'h3000 + alu, 5'd0, alu, 1'b0));
        issue(op, 32'h3000 + alu, alu, 5'd12, data);
        bus.ex_valid = 1'b0;
        check("store_we",    32'(bus.dmem_we), 32'd1);
        check("store_be",    32'(bus.dmem_be), 32'(be));
        check("store_wdata", bus.dmem_wdata,   wdata);
        check("store_addr",  bus.dmem_addr,    {alu[31:2], 2'b00});
        mem_handshake(0, 1'b0, 32'h0, rc);
        check("store_req_cycles", 32'(rc), 32'd1);
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc;
        bus.ex_valid = 1'b0; bus.ex_opcode = 6'd0; bus.ex_pc = 32'd0; bus.alu_out = 32'd0;
        bus.ex_rf_dest = 5'd0; bus.ex_mem_data = 32'd0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
        bus.mem_ready = 1'b1;

        // Reset state
        tick(3);
        @(negedge clk);
        check("rst_ex_ready",   32'(bus.ex_ready),   32'd1);
        check("rst_mem_valid",  32'(bus.mem_valid),  32'd0);
        check("rst_dmem_req",   32'(bus.dmem_req),   32'd0);
        check("rst_dmem_be",    32'(bus.dmem_be),    32'd0);
        check("rst_mem_result", bus.mem_result,      32'd0);
        rst_n = 1'b1;
        tick(1);

        // Back-to-back non-memory ops, no bubble
        sb_q.push_back(mk(6'h00, 32'h10, 5'd3, 32'd5, 1'b0));
        sb_q.push_back(mk(6'h00, 32'h14, 5'd4, 32'd7, 1'b0));
        issue(6'h00, 32'h10, 32'd5, 5'd3, 32'd0);
        issue(6'h00, 32'h14, 32'd7, 5'd4, 32'd0);
        bus.ex_valid = 1'b0;
        tick(3);
        check("b2b_spacing", 32'(last_pop_cyc - prev_pop_cyc), 32'd1);

        // Loads: lane select, sign/zero extension, delayed grant
        load_op(6'h20, 32'h103, 2, 32'h80112233, 4'b1000, 32'hFFFFFF80);
        load_op(6'h24, 32'h103, 2, 32'h80112233, 4'b1000, 32'h00000080);
        load_op(6'h21, 32'h102, 1, 32'h80112233, 4'b1100, 32'hFFFF8011);
        load_op(6'h25, 32'h102, 0, 32'h80112233, 4'b1100, 32'h00008011);
        load_op(6'h23, 32'h104, 0, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);

        // Stores: byte-lane replication and enables
        store_op(6'h29, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
        store_op(6'h28, 32'h201, 32'h123456EF, 4'b0010, 32'hEFEFEFEF);
        store_op(6'h2B, 32'h208, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        // Misaligned word load is trapped
        sb_q.push_back(mk(6'h23, 32'h40, 5'd0, 32'h101, 1'b1));
        issue(6'h23, 32'h40, 32'h101, 5'd8, 32'd0);
        bus.ex_valid = 1'b0;
        check("mis_req",   32'(bus.dmem_req),       32'd0);
        check("mis_valid", 32'(bus.mem_valid),      32'd1);
        check("mis_flag",  32'(bus.mem_misaligned), 32'd1);
        @(negedge clk);
        check("mis_req_later", 32'(bus.dmem_req), 32'd0);
        tick(2);

        // Writeback stall holds outputs and blocks Execute
        bus.mem_ready = 1'b0;
        sb_q.push_back(mk(6'h00, 32'h50, 5'd9, 32'h55, 1'b0));
        issue(6'h00, 32'h50, 32'h55, 5'd9, 32'd0);
        bus.ex_pc = 32'h54; bus.alu_out = 32'h66; bus.ex_rf_dest = 5'd10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid",  32'(bus.mem_valid),   32'd1);
            check("stall_result", bus.mem_result,       32'h55);
            check("stall_dest",   32'(bus.mem_rf_dest), 32'd9);
            check("stall_pc",     bus.mem_pc,           32'h50);
            check("stall_ready",  32'(bus.ex_ready),    32'd0);
            @(posedge clk);
            #1;
        end
        sb_q.push_back(mk(6'h00, 32'h54, 5'd10, 32'h66, 1'b0));
        bus.mem_ready = 1'b1;
        tick(1);
        bus.ex_valid = 1'b0;
        tick(2);

        // Reset in REQ drops the request immediately; a late grant is ignored
        issue(6'h23, 32'h60, 32'h300, 5'd11, 32'd0);
        bus.ex_valid = 1'b0;
        check("pre_rst_req", 32'(bus.dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_drop",   32'(bus.dmem_req),  32'd0);
        check("rst_req_ready",  32'(bus.ex_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dmem_gnt = 1'b1;
        tick(1);
        bus.dmem_gnt = 1'b0;
        check("late_gnt_req",   32'(bus.dmem_req),  32'd0);
        check("late_gnt_valid", 32'(bus.mem_valid), 32'd0);

        // Reset in WAIT; a late rvalid causes no output change
        issue(6'h23, 32'h64, 32'h304, 5'd13, 32'd0);
        bus.ex_valid = 1'b0;
        mem_handshake(0, 1'b0, 32'h0, rc);
        check("wait_valid", 32'(bus.mem_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_req",   32'(bus.dmem_req),  32'd0);
        check("rst_wait_valid", 32'(bus.mem_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h12345678;
        tick(1);
        bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rv_valid",  32'(bus.mem_valid), 32'd0);
        check("late_rv_result", bus.mem_result,     32'd0);
        check("late_rv_ready",  32'(bus.ex_ready),  32'd1);
        tick(2);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
